// File: rtl/ps2_scancode_encoder_pkg.sv
// ---------------------------------------------------------------------------
// ps2_scancode_encoder_pkg
// Shared constants for the PS/2 Set-2 scan-code encoder and any decoder that
// must agree with it: key index assignments, per-key scan codes, the break
// prefix byte and the encoder FSM state encodings.
// key_to_code() is the single index->code table, so the encoder ROM and a
// decoder case table built from these constants cannot drift apart.
// ---------------------------------------------------------------------------
package ps2_scancode_encoder_pkg;

   // Width of the key-state vector.
   localparam int unsigned NUMBEROFKEYBOARDINPUTS = 8;

   // Key indices (bit positions in the key-state vector).
   localparam int unsigned KEY_RELEASE_PULSE = 0;
   localparam int unsigned KEY_TILDA         = 1;
   localparam int unsigned KEY_Q             = 2;
   localparam int unsigned KEY_W             = 3;
   localparam int unsigned KEY_1             = 4;
   localparam int unsigned KEY_2             = 5;
   localparam int unsigned KEY_A             = 6;
   localparam int unsigned KEY_SPACEBAR      = 7;

   // Set-2 make codes.
   localparam logic [7:0] SC_NONE      = 8'h00;
   localparam logic [7:0] SC_TILDA     = 8'h0E;
   localparam logic [7:0] SC_Q         = 8'h15;
   localparam logic [7:0] SC_W         = 8'h1D;
   localparam logic [7:0] SC_1         = 8'h16;
   localparam logic [7:0] SC_2         = 8'h1E;
   localparam logic [7:0] SC_A         = 8'h1C;
   localparam logic [7:0] SC_SPACEBAR  = 8'h29;
   localparam logic [7:0] BREAK_PREFIX = 8'hF0;

   // Encoder FSM state encodings.
   localparam logic [1:0] ENC_SCAN   = 2'd0;
   localparam logic [1:0] ENC_PREFIX = 2'd1;
   localparam logic [1:0] ENC_CODE   = 2'd2;

   // Index -> make code; SC_NONE marks an index that is never emitted.
   function automatic logic [7:0] key_to_code(input int unsigned idx);
      logic [7:0] code;
      case (idx)
         KEY_TILDA:    code = SC_TILDA;
         KEY_Q:        code = SC_Q;
         KEY_W:        code = SC_W;
         KEY_1:        code = SC_1;
         KEY_2:        code = SC_2;
         KEY_A:        code = SC_A;
         KEY_SPACEBAR: code = SC_SPACEBAR;
         default:      code = SC_NONE;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/ps2_key_to_scancode.sv
// ---------------------------------------------------------------------------
// ps2_key_to_scancode
// Combinational key-index -> Set-2 make-code ROM. Unmapped indices return
// 8'h00 ("no key").
// Ports:
//   i_idx   in  IDX_W  key index
//   o_code  out 8      make code, 8'h00 when the index has no key
// ---------------------------------------------------------------------------
module ps2_key_to_scancode
   import ps2_scancode_encoder_pkg::*;
#(
   parameter int unsigned IDX_W = 3
) (
   input  logic [IDX_W-1:0] i_idx,
   output logic [7:0]       o_code
);

   // ROM lookup through the shared table.
   always_comb begin
      o_code = key_to_code(32'(i_idx));
   end

endmodule

// File: rtl/ps2_scancode_encoder.sv
// ---------------------------------------------------------------------------
// ps2_scancode_encoder
// Turns a key-state vector into a PS/2 Set-2 byte stream: a newly pressed key
// produces its make code, a released key produces F0 followed by the make
// code. One index is examined per cycle in round-robin order; after every
// emitted sequence the scan resumes at the index after the emitted key.
// Optional feature macro: TYPEMATIC_EN (auto-repeat of the last key made).
// Ports:
//   CLOCK_50   in   1         system clock
//   resetn     in   1         asynchronous active-low reset
//   enable     in   1         allow new sequences to start
//   keyState   in   NUM_KEYS  desired pressed state per key index
//   byteOut    out  8         byte offered downstream, stable while offered
//   byteValid  out  1         byteOut is offered
//   byteReady  in   1         downstream accepts byteOut this cycle
//   sentState  out  NUM_KEYS  key state already encoded on the stream
//   busy       out  1         a make/break sequence is in progress
// ---------------------------------------------------------------------------
module ps2_scancode_encoder
   import ps2_scancode_encoder_pkg::*;
#(
   parameter int unsigned NUM_KEYS         = NUMBEROFKEYBOARDINPUTS,
   parameter int unsigned TYPEMATIC_DELAY  = 25000000,
   parameter int unsigned TYPEMATIC_PERIOD = 5000000
) (
   input  logic                CLOCK_50,
   input  logic                resetn,
   input  logic                enable,
   input  logic [NUM_KEYS-1:0] keyState,
   output logic [7:0]          byteOut,
   output logic                byteValid,
   input  logic                byteReady,
   output logic [NUM_KEYS-1:0] sentState,
   output logic                busy
);

   localparam int unsigned     IDX_W    = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_KEYS - 1);

   logic [1:0]          r_state;
   logic [IDX_W-1:0]    r_idx;
   logic [IDX_W-1:0]    r_lat_idx;
   logic                r_dir;
   logic [7:0]          r_code;
   logic [7:0]          r_byte;
   logic                r_valid;
   logic                r_busy;
   logic [NUM_KEYS-1:0] r_sent;

   logic [7:0]          w_scan_code;
   logic                w_change;
   logic [IDX_W-1:0]    w_scan_next;
   logic [IDX_W-1:0]    w_lat_next;

   ps2_key_to_scancode #(.IDX_W(IDX_W)) u_rom_scan (
      .i_idx  (r_idx),
      .o_code (w_scan_code)
   );

   assign w_change    = enable && (w_scan_code != SC_NONE) && (keyState[r_idx] != r_sent[r_idx]);
   assign w_scan_next = (r_idx == LAST_IDX) ? {IDX_W{1'b0}} : r_idx + IDX_W'(1);
   assign w_lat_next  = (r_lat_idx == LAST_IDX) ? {IDX_W{1'b0}} : r_lat_idx + IDX_W'(1);

`ifdef TYPEMATIC_EN
   logic [IDX_W-1:0] r_rep_idx;
   logic             r_rep_arm;
   logic [31:0]      r_rep_cnt;
   logic             r_is_rep;
   logic [7:0]       w_rep_code;
   logic             w_rep_due;
   logic             w_done;

   ps2_key_to_scancode #(.IDX_W(IDX_W)) u_rom_rep (
      .i_idx  (r_rep_idx),
      .o_code (w_rep_code)
   );

   // A repeat is only due while the key is still held and already reported.
   assign w_rep_due = enable && r_rep_arm && (r_rep_cnt == 32'd0) &&
                      keyState[r_rep_idx] && r_sent[r_rep_idx];
   assign w_done    = (r_state == ENC_CODE) && byteReady;

   // Repeat target and timer: retarget on every make, cancel on its break.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         r_rep_idx <= {IDX_W{1'b0}};
         r_rep_arm <= 1'b0;
         r_rep_cnt <= 32'd0;
      end else if (w_done && r_dir && !r_is_rep) begin
         r_rep_idx <= r_lat_idx;
         r_rep_arm <= 1'b1;
         r_rep_cnt <= 32'(TYPEMATIC_DELAY);
      end else if (w_done && !r_dir && (r_lat_idx == r_rep_idx)) begin
         r_rep_arm <= 1'b0;
         r_rep_cnt <= 32'd0;
      end else if (w_done && r_is_rep) begin
         r_rep_cnt <= 32'(TYPEMATIC_PERIOD);
      end else if (r_rep_cnt != 32'd0) begin
         r_rep_cnt <= r_rep_cnt - 32'd1;
      end else begin
         r_rep_cnt <= r_rep_cnt;
      end
   end
`else
   // Timing parameters only matter when auto-repeat is built in.
   logic w_unused_tm;
   assign w_unused_tm = ^{32'(TYPEMATIC_DELAY), 32'(TYPEMATIC_PERIOD)};
`endif

   // Main sequencer: scan for changes, then present prefix/code under valid/ready.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         r_state   <= ENC_SCAN;
         r_idx     <= {IDX_W{1'b0}};
         r_lat_idx <= {IDX_W{1'b0}};
         r_dir     <= 1'b0;
         r_code    <= 8'h00;
         r_byte    <= 8'h00;
         r_valid   <= 1'b0;
         r_busy    <= 1'b0;
         r_sent    <= {NUM_KEYS{1'b0}};
`ifdef TYPEMATIC_EN
         r_is_rep  <= 1'b0;
`endif
      end else begin
         case (r_state)
            ENC_SCAN: begin
               if (w_change) begin
                  // keyState is sampled only here; later changes wait for a rescan.
                  r_lat_idx <= r_idx;
                  r_dir     <= keyState[r_idx];
                  r_code    <= w_scan_code;
                  r_valid   <= 1'b1;
                  r_busy    <= 1'b1;
`ifdef TYPEMATIC_EN
                  r_is_rep  <= 1'b0;
`endif
                  if (keyState[r_idx]) begin
                     r_byte  <= w_scan_code;
                     r_state <= ENC_CODE;
                  end else begin
                     r_byte  <= BREAK_PREFIX;
                     r_state <= ENC_PREFIX;
                  end
               end
`ifdef TYPEMATIC_EN
               else if (w_rep_due) begin
                  // Repeat is a bare make byte; the scan position is left alone.
                  r_lat_idx <= r_rep_idx;
                  r_dir     <= 1'b1;
                  r_code    <= w_rep_code;
                  r_byte    <= w_rep_code;
                  r_valid   <= 1'b1;
                  r_busy    <= 1'b1;
                  r_is_rep  <= 1'b1;
                  r_state   <= ENC_CODE;
               end
`endif
               else begin
                  r_idx <= w_scan_next;
               end
            end
            ENC_PREFIX: begin
               if (byteReady) begin
                  // valid stays high: the code follows F0 with no bubble.
                  r_byte  <= r_code;
                  r_state <= ENC_CODE;
               end else begin
                  r_state <= ENC_PREFIX;
               end
            end
            ENC_CODE: begin
               if (byteReady) begin
                  r_sent[r_lat_idx] <= r_dir;
                  r_valid           <= 1'b0;
                  r_busy            <= 1'b0;
                  r_state           <= ENC_SCAN;
`ifdef TYPEMATIC_EN
                  if (!r_is_rep) begin
                     r_idx <= w_lat_next;
                  end else begin
                     r_idx <= r_idx;
                  end
`else
                  r_idx             <= w_lat_next;
`endif
               end else begin
                  r_state <= ENC_CODE;
               end
            end
            default: begin
               r_state <= ENC_SCAN;
               r_valid <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign byteOut   = r_byte;
   assign byteValid = r_valid;
   assign busy      = r_busy;
   assign sentState = r_sent;

endmodule

// File: tb/tb_ps2_scancode_encoder.sv
// ---------------------------------------------------------------------------
// tb_ps2_scancode_encoder
// Directed self-checking bench for ps2_scancode_encoder. Inputs change 1 time
// unit after the rising edge; the accepted-byte and busy counters sample on
// the falling edge. With TYPEMATIC_EN defined the auto-repeat sequence runs
// after the reset checks instead of the make/break sequence.
// ---------------------------------------------------------------------------
module tb_ps2_scancode_encoder;
   import ps2_scancode_encoder_pkg::*;

   localparam int unsigned NK = NUMBEROFKEYBOARDINPUTS;
`ifdef TYPEMATIC_EN
   localparam int unsigned TD = 20;
   localparam int unsigned TP = 10;
`else
   localparam int unsigned TD = 25000000;
   localparam int unsigned TP = 5000000;
`endif

   logic          clk;
   logic          resetn;
   logic          enable;
   logic [NK-1:0] keyState;
   logic [7:0]    byteOut;
   logic          byteValid;
   logic          byteReady;
   logic [NK-1:0] sentState;
   logic          busy;

   int errors   = 0;
   int checks   = 0;
   int acc_cnt  = 0;
   int busy_cnt = 0;

   ps2_scancode_encoder #(
      .NUM_KEYS         (NK),
      .TYPEMATIC_DELAY  (TD),
      .TYPEMATIC_PERIOD (TP)
   ) dut (
      .CLOCK_50  (clk),
      .resetn    (resetn),
      .enable    (enable),
      .keyState  (keyState),
      .byteOut   (byteOut),
      .byteValid (byteValid),
      .byteReady (byteReady),
      .sentState (sentState),
      .busy      (busy)
   );

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   // Count bytes that will be accepted on the next rising edge, and busy cycles.
   always @(negedge clk) begin
      if (byteValid && byteReady) acc_cnt <= acc_cnt + 1;
      if (busy) busy_cnt <= busy_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Wait (bounded) for an offered byte, optionally stall, then accept it.
   task automatic take(input string tag, input logic [7:0] exp, input int stall, output int waited);
      logic [7:0] first;
      logic       stable;
      waited = 0;
      while (!byteValid && waited < 200) begin
         @(posedge clk); #1;
         waited++;
      end
      chk({tag, "_valid"}, 32'(byteValid), 32'd1);
      first  = byteOut;
      stable = 1'b1;
      if (stall > 0) begin
         byteReady = 1'b0;
         for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            if (byteOut !== first || byteValid !== 1'b1) stable = 1'b0;
         end
         byteReady = 1'b1;
         chk({tag, "_stable"}, 32'(stable), 32'd1);
      end
      @(posedge clk); #1;
      chk(tag, 32'(first), 32'(exp));
   endtask

   initial begin
      int            w;
      int            a0;
      int            b0;
      logic [NK-1:0] exp_s;

      resetn    = 1'b0;
      enable    = 1'b1;
      byteReady = 1'b1;
      keyState  = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 32'(byteValid), 32'd0);
      chk("rst_byte",  32'(byteOut),   32'h00);
      chk("rst_busy",  32'(busy),      32'd0);
      chk("rst_sent",  32'(sentState), 32'd0);

      // Idle with ready high: nothing may be offered.
      resetn = 1'b1;
      a0 = acc_cnt;
      repeat (100) @(posedge clk);
      #1;
      chk("idle_bytes", 32'(acc_cnt - a0), 32'd0);
      chk("idle_valid", 32'(byteValid),    32'd0);
      chk("idle_sent",  32'(sentState),    32'd0);

`ifdef TYPEMATIC_EN
      // Hold W: make, first repeat after ~TD, then every ~TP.
      keyState[KEY_W] = 1'b1;
      take("tm_make", 8'h1D, 0, w);
      take("tm_rep1", 8'h1D, 0, w);
      chk("tm_rep1_gap", 32'(w >= 18 && w <= 22), 32'd1);
      take("tm_rep2", 8'h1D, 0, w);
      chk("tm_rep2_gap", 32'(w >= 8 && w <= 12), 32'd1);
      keyState[KEY_W] = 1'b0;
      take("tm_brk_f0", 8'hF0, 0, w);
      take("tm_brk_code", 8'h1D, 0, w);
      chk("tm_brk_nobubble", 32'(w), 32'd0);
      a0 = acc_cnt;
      repeat (60) @(posedge clk);
      #1;
      chk("tm_no_more", 32'(acc_cnt - a0), 32'd0);
      chk("tm_sent",    32'(sentState),    32'd0);
`else
      // Press Q: exactly one make byte, busy for one cycle.
      a0 = acc_cnt;
      b0 = busy_cnt;
      keyState[KEY_Q] = 1'b1;
      take("make_q", 8'h15, 0, w);
      exp_s = '0;
      exp_s[KEY_Q] = 1'b1;
      chk("make_q_sent", 32'(sentState), 32'(exp_s));
      repeat (20) @(posedge clk);
      #1;
      chk("make_q_count", 32'(acc_cnt - a0),  32'd1);
      chk("make_q_busy",  32'(busy_cnt - b0), 32'd1);

      // Release Q: F0 then 15 with no bubble.
      keyState[KEY_Q] = 1'b0;
      take("brk_q_f0", 8'hF0, 0, w);
      take("brk_q_code", 8'h15, 0, w);
      chk("brk_q_nobubble", 32'(w), 32'd0);
      chk("brk_q_sent", 32'(sentState), 32'd0);

      // Scan now sits just after Q, so key1 is reached before spacebar.
      keyState[KEY_1]        = 1'b1;
      keyState[KEY_SPACEBAR] = 1'b1;
      take("two_first",  8'h16, 5, w);
      take("two_second", 8'h29, 5, w);
      exp_s = '0;
      exp_s[KEY_1]        = 1'b1;
      exp_s[KEY_SPACEBAR] = 1'b1;
      chk("two_sent", 32'(sentState), 32'(exp_s));

      // Tilda pressed, then released while disabled.
      keyState[KEY_TILDA] = 1'b1;
      take("make_tilda", 8'h0E, 0, w);
      enable = 1'b0;
      keyState[KEY_TILDA] = 1'b0;
      a0 = acc_cnt;
      repeat (30) @(posedge clk);
      #1;
      chk("dis_bytes", 32'(acc_cnt - a0), 32'd0);
      chk("dis_busy",  32'(busy),         32'd0);
      enable = 1'b1;
      take("brk_tilda_f0", 8'hF0, 0, w);
      chk("brk_tilda_pending", 32'(byteOut), 32'h0E);

      // Reset between F0 and the code: the code is dropped.
      resetn   = 1'b0;
      keyState = '0;
      #1;
      chk("mid_rst_valid", 32'(byteValid), 32'd0);
      chk("mid_rst_byte",  32'(byteOut),   32'h00);
      chk("mid_rst_busy",  32'(busy),      32'd0);
      chk("mid_rst_sent",  32'(sentState), 32'd0);
      a0 = acc_cnt;
      repeat (5) @(posedge clk);
      #1;
      resetn = 1'b1;
      repeat (50) @(posedge clk);
      #1;
      chk("post_rst_bytes", 32'(acc_cnt - a0), 32'd0);
      chk("post_rst_valid", 32'(byteValid),    32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
